subbytes_seq: RTL and testbench

Parametrised, sequential AES SubBytes/InvSubBytes engine. It accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through forward or inverse S-box lanes. It returns the full substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the round datapath and trades latency for S-box area against the fully combinational 16-lane SubBytes stage.

---
 rtl/aes_sbox_pkg.sv | 43 ++++
 rtl/sbox_lane.sv | 10 +
 rtl/subbytes_seq.sv | 75 +++++++
 tb/tb_subbytes_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg: FIPS-197 forward/inverse S-box tables, SubBytes engine state encoding and lane-count check
package aes_sbox_pkg;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  function automatic bit lanes_ok(int lanes);
    return lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8 || lanes == 16;
  endfunction
endpackage

// File: rtl/sbox_lane.sv
// sbox_lane: one combinational forward/inverse AES S-box lookup
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic       encode,
  input  logic [7:0] in,
  output logic [7:0] out
);
  assign out = encode ? SBOX[in] : INV_SBOX[in];
endmodule

// File: rtl/subbytes_seq.sv
// subbytes_seq: sequential AES SubBytes/InvSubBytes, LANES bytes substituted in place per beat
module subbytes_seq
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4,
  localparam int BEATS = 16 / LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_encode,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_encode,
  output logic [127:0] out_state
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  buf_q, buf_d;
  logic          mode_q, mode_d;
  logic          last;
  logic [7:0]    lane_out [LANES];
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox_lane u_lane (
      .encode (mode_q),
      .in     (buf_q[8*(int'(cnt_q)*LANES+j) +: 8]),
      .out    (lane_out[j])
    );
  end
  assign last       = cnt_q == CW'(BEATS - 1);
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_encode = mode_q;
  assign out_state  = buf_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SUB;
        cnt_d   = '0;
        buf_d   = in_state;
        mode_d  = in_encode;
      end
      SUB: begin
        for (int i = 0; i < LANES; i++) buf_d[8*(int'(cnt_q)*LANES+i) +: 8] = lane_out[i];
        state_d = last ? DONE : SUB;
        cnt_d   = last ? cnt_q : cnt_q + CW'(1);
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: tb/tb_subbytes_seq.sv
// tb_subbytes_seq: directed and random checks of subbytes_seq for LANES = 1, 2, 4, 8, 16 against a GF(2^8) model
module tb_subbytes_seq;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv [5], ir [5], ie [5], ov [5], ordy [5], oe [5];
  logic [127:0] ist [5], ost [5];
  logic [7:0]   fwd [256], inv [256];
  int           n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  // instance g runs with LANES = 2**g
  for (genvar g = 0; g < 5; g++) begin : g_dut
    subbytes_seq #(.LANES(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv[g]),
      .in_ready   (ir[g]),
      .in_encode  (ie[g]),
      .in_state   (ist[g]),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_encode (oe[g]),
      .out_state  (ost[g])
    );
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a = a_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  // multiplicative inverse as x^254, then the FIPS-197 affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic en);
    logic [127:0] r = s;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = en ? fwd[s[8*i +: 8]] : inv[s[8*i +: 8]];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input int k, input logic [127:0] st, input logic en);
    int t = 0;
    while (ir[k] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("in_ready_before_send_%0d", k), 128'(ir[k]), 128'(1'b1));
    iv[k] = 1'b1;
    ist[k] = st;
    ie[k] = en;
    @(negedge clk);
    iv[k] = 1'b0;
  endtask
  task automatic recv(input int k, output logic [127:0] st, output logic en, output int lat);
    lat = 1;
    while (ov[k] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    st = ost[k];
    en = oe[k];
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask
  initial begin
    logic [127:0] st, res, res2, got0, got1;
    logic         en, oen, gen0, gen1, bad, ir_seen;
    int           lat, idx, nout, cyc, acc0, acc1;
    for (int x = 0; x < 256; x++) fwd[x] = sbox_calc(8'(x));
    for (int x = 0; x < 256; x++) inv[fwd[x]] = 8'(x);
    for (int k = 0; k < 5; k++) begin
      iv[k] = 1'b0;
      ie[k] = 1'b0;
      ist[k] = '0;
      ordy[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset_in_ready_%0d", k), 128'(ir[k]), 128'(1'b1));
      chk($sformatf("reset_out_valid_%0d", k), 128'(ov[k]), 128'(1'b0));
      chk($sformatf("reset_out_encode_%0d", k), 128'(oe[k]), 128'(1'b0));
      chk($sformatf("reset_out_state_%0d", k), ost[k], '0);
    end
    // reset dropped during SUB beat 2, LANES=4
    send(2, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_in_ready", 128'(ir[2]), 128'(1'b1));
    chk("rst_mid_out_state", ost[2], '0);
    chk("rst_mid_out_encode", 128'(oe[2]), 128'(1'b0));
    bad = 1'b0;
    repeat (8) begin
      bad |= ov[2];
      @(negedge clk);
    end
    chk("rst_mid_no_out_valid", 128'(bad), 128'(1'b0));
    // forward, LANES=4
    for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(i);
    send(2, st, 1'b1);
    recv(2, res, oen, lat);
    chk("fwd_latency", 128'(lat), 128'(5));
    chk("fwd_known_answer", res, 128'h76abd7fe2b670130c56f6bf27b777c63);
    chk("fwd_model", res, ref_sub(st, 1'b1));
    chk("fwd_out_encode", 128'(oen), 128'(1'b1));
    // inverse round trip, LANES=1
    send(0, res, 1'b0);
    recv(0, res2, oen, lat);
    chk("inv_roundtrip", res2, st);
    chk("inv_latency", 128'(lat), 128'(17));
    chk("inv_out_encode", 128'(oen), 128'(1'b0));
    // backpressure, LANES=16, with an ignored in_valid pulse while busy
    send(4, {16{8'h53}}, 1'b1);
    lat = 1;
    while (ov[4] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'(2));
    ir_seen = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ir_seen |= ir[4];
      bad |= (ov[4] !== 1'b1) || (ost[4] !== {16{8'hed}}) || (oe[4] !== 1'b1);
      iv[4] = (c == 3);
      ist[4] = '0;
      ie[4] = 1'b0;
      @(negedge clk);
    end
    iv[4] = 1'b0;
    chk("bp_in_ready_low", 128'(ir_seen), 128'(1'b0));
    chk("bp_output_held", 128'(bad), 128'(1'b0));
    chk("bp_value", ost[4], ref_sub({16{8'h53}}, 1'b1));
    ordy[4] = 1'b1;
    @(negedge clk);
    ordy[4] = 1'b0;
    chk("bp_released_out_valid", 128'(ov[4]), 128'(1'b0));
    chk("bp_released_in_ready", 128'(ir[4]), 128'(1'b1));
    // back-to-back, LANES=8, in_valid held continuously
    idx = 0;
    nout = 0;
    cyc = 0;
    acc0 = -100;
    acc1 = 100;
    got0 = '0;
    got1 = '0;
    gen0 = 1'b0;
    gen1 = 1'b1;
    ordy[3] = 1'b1;
    while ((idx < 2 || nout < 2) && cyc < 60) begin
      if (ov[3] === 1'b1 && nout < 2) begin
        if (nout == 0) begin
          got0 = ost[3];
          gen0 = oe[3];
        end else begin
          got1 = ost[3];
          gen1 = oe[3];
        end
        nout++;
      end
      if (idx < 2) begin
        iv[3] = 1'b1;
        ist[3] = idx == 0 ? {16{8'hff}} : {16{8'h16}};
        ie[3] = idx == 0;
        if (ir[3] === 1'b1) begin
          if (idx == 0) acc0 = cyc;
          else acc1 = cyc;
          idx++;
        end
      end else iv[3] = 1'b0;
      @(negedge clk);
      cyc++;
    end
    iv[3] = 1'b0;
    ordy[3] = 1'b0;
    chk("b2b_accept_spacing", 128'(acc1 - acc0), 128'(4));
    chk("b2b_out_count", 128'(nout), 128'(2));
    chk("b2b_first_value", got0, {16{8'h16}});
    chk("b2b_first_encode", 128'(gen0), 128'(1'b1));
    chk("b2b_second_value", got1, {16{8'hff}});
    chk("b2b_second_encode", 128'(gen1), 128'(1'b0));
    // mode isolation, LANES=2: in_encode toggles while the block is in flight
    send(1, '0, 1'b0);
    lat = 1;
    while (ov[1] !== 1'b1 && lat < 50) begin
      ie[1] = ~ie[1];
      @(negedge clk);
      lat++;
    end
    chk("iso_latency", 128'(lat), 128'(9));
    chk("iso_value", ost[1], {16{8'h52}});
    chk("iso_out_encode", 128'(oe[1]), 128'(1'b0));
    ordy[1] = 1'b1;
    @(negedge clk);
    ordy[1] = 1'b0;
    // random states and modes on every lane count
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 4; n++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        en = 1'($urandom);
        send(k, st, en);
        recv(k, res, oen, lat);
        chk($sformatf("rand_value_l%0d_%0d", 1 << k, n), res, ref_sub(st, en));
        chk($sformatf("rand_encode_l%0d_%0d", 1 << k, n), 128'(oen), 128'(en));
        chk($sformatf("rand_latency_l%0d_%0d", 1 << k, n), 128'(lat), 128'((16 >> k) + 1));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
